top_main_core: RTL and testbench
================================

# top_main_core

Self-contained compute kernel that sits at the top of the accelerator and streams results into an external 2048-word result RAM through a simple write port. It has an HLS-style ap_start/ap_done handshake and a global clock-enable (clk_en) that freezes all state for task-interruption save/restore. It also has a cycle breakpoint that stalls execution once a programmed number of run cycles has elapsed. The kernel writes word i = i*(i+1)/2 (triangular numbers, mod 2^32) to address i.

## Interface
- N_WORDS, 2048: number of result words written per run (1..2048).
- sys_clk  in  1  single clock; all state updates on rising edge.
- sys_resetn  in  1  reset is asynchronous and active-low.
- clk_en  in  1  1 = normal operation; 0 = freeze all state.
- breakpoint  in  32  run-cycle count at which execution stalls; 0xFFFF_FFFF = effectively none.
- ap_start  in  1  level start request.
- ap_done  out  1  run complete, held until ap_start drops.
- write_address  out  11  result RAM word address.
- write_data  out  32  result word.
- write_enable  out  1  one-cycle write strobe per word.

## Operation
- Registers:
  - state: IDLE, RUN, DONE.
  - idx: 11-bit word index.
  - acc: 32-bit accumulator.
  - cyc: 32-bit run-cycle counter.
  - All outputs are registered.
- Effective enable: en = clk_en & ~(state==RUN & cyc==breakpoint).
- When en=0 on an edge:
  - write_enable <= 0.
  - All other registers hold, including write_address, write_data, ap_done, idx, acc, cyc and state.
- IDLE:
  - ap_done=0, write_enable=0.
  - If ap_start=1 and clk_en=1: go to RUN with idx<=0, acc<=0, cyc<=0.
- RUN, each edge with en=1:
  - acc_next = acc + idx (32-bit wrap).
  - write_address <= idx, write_data <= acc_next, write_enable <= 1.
  - acc <= acc_next, cyc <= cyc+1.
  - If idx == N_WORDS-1: state <= DONE and ap_done <= 1. Otherwise idx <= idx+1.
- DONE:
  - write_enable <= 0.
  - ap_done stays 1 while ap_start=1.
  - When ap_start=0 (with clk_en=1): ap_done <= 0 and go to IDLE.
  - A new run needs ap_start to go low and then high again.
- Breakpoint compare is unsigned equality on cyc.
  - Once cyc==breakpoint, RUN stalls with no writes and no counting.
  - The stall ends only when the breakpoint input changes or reset is asserted.
  - breakpoint=0 stalls before the first write.
- ap_start is ignored in RUN.
- Reset (async, any time including mid-run):
  - state=IDLE, ap_done=0, write_enable=0, write_address=0, write_data=0, idx=0, acc=0, cyc=0.

## Timing
- Start latency: ap_start sampled high at edge k enters RUN. The first write strobe appears after edge k+1 (address 0, data 0).
- Throughput: one word per enabled cycle. Words are written at consecutive addresses with no gaps unless clk_en=0 or a breakpoint stall occurs.
- Completion: the last write (address N_WORDS-1) and the rise of ap_done happen on the same edge, k+N_WORDS, when there are no stalls.
- Write strobe: write_enable is high for exactly one cycle per word. It is never high on a cycle following an edge where en=0.
- Freeze/resume: deasserting clk_en for any number of cycles and then reasserting it resumes at the next index with no skipped or duplicated words.
- Reset release: the first start can be accepted on the first edge after sys_resetn rises.

## Test plan
- Reset 100 ns, ap_start=1 at 200 ns, breakpoint=0xFFFF_FFFF:
  - 2048 strobes; address 0 -> 0, 5 -> 15, 2047 -> 2096128.
  - ap_done rises with the final strobe and stays high while ap_start=1.
- clk_en=0 for 4 cycles mid-run (at idx 100):
  - No strobes during the freeze.
  - The next strobe is address 100, data 5050.
  - The total is still exactly 2048 strobes.
- breakpoint=10:
  - Exactly addresses 0..9 are written, then the core stalls with ap_done=0.
  - Setting breakpoint=0xFFFF_FFFF resumes at address 10, data 55.
- Assert sys_resetn=0 at idx 500, asynchronously:
  - Outputs go to 0 immediately.
  - After release with ap_start=1, the run restarts from address 0.
- Handshake: after DONE, hold ap_start=1:
  - No restart and ap_done stays 1.
  - Drop ap_start: ap_done falls the next edge.
  - Reassert ap_start: a new full run occurs.
- N_WORDS=1: a single strobe with address 0, data 0, and ap_done rises on that same edge.

Source files
------------

// File: rtl/top_main_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// top_main_core
//
// Compute kernel that streams triangular numbers (word i = i*(i+1)/2, mod 2^32)
// into an external result RAM through a single-word write port. Runs are
// launched with an ap_start/ap_done level handshake. A global clock-enable
// freezes all state, and a run-cycle breakpoint stalls the kernel after a
// programmed number of run cycles.
//
// Ports:
//   sys_clk        in   1   clock, all state updates on the rising edge
//   sys_resetn     in   1   asynchronous active-low reset
//   clk_en         in   1   1 = run, 0 = freeze all state
//   breakpoint     in  32   run-cycle count at which RUN stalls
//   ap_start       in   1   level start request
//   ap_done        out  1   run complete, held until ap_start drops
//   write_address  out 11   result RAM word address
//   write_data     out 32   result word
//   write_enable   out  1   one-cycle write strobe per word
// -----------------------------------------------------------------------------
module top_main_core #(
    parameter int N_WORDS = 2048
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic        clk_en,
    input  logic [31:0] breakpoint,
    input  logic        ap_start,
    output logic        ap_done,
    output logic [10:0] write_address,
    output logic [31:0] write_data,
    output logic        write_enable
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [10:0] LAST_IDX = 11'(N_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [10:0] idx_q,   idx_d;
    logic [31:0] acc_q,   acc_d;
    logic [31:0] cyc_q,   cyc_d;
    logic        done_q,  done_d;
    logic [10:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q,   wen_d;

    logic        bp_hit;
    logic        en;
    logic [31:0] acc_next;

    // The breakpoint only gates RUN; IDLE and DONE follow clk_en alone.
    assign bp_hit = (state_q == S_RUN) && (cyc_q == breakpoint);
    assign en     = clk_en && !bp_hit;

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no
        // path through the case statement can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cyc_d    = cyc_q;
        done_d   = done_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;      // strobe drops on any cycle that does not write
        acc_next = acc_q + {21'd0, idx_q};

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    done_d = 1'b0;
                    if (ap_start) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                        acc_d   = '0;
                        cyc_d   = '0;
                    end
                end
                S_RUN: begin
                    // Running sum of indices gives the triangular number for
                    // the current index in the same cycle it is written.
                    waddr_d = idx_q;
                    wdata_d = acc_next;
                    wen_d   = 1'b1;
                    acc_d   = acc_next;
                    cyc_d   = cyc_q + 32'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
                S_DONE: begin
                    if (!ap_start) begin
                        done_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
        end
    end

    assign ap_done       = done_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign write_enable  = wen_q;

endmodule

// File: tb/tb_top_main_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_top_main_core
//
// Directed bench for top_main_core. A 2048-word instance covers full runs,
// freeze, breakpoint, mid-run reset and the handshake; a second instance with
// N_WORDS=1 covers the single-word boundary. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_top_main_core;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [31:0] breakpoint;
    logic        ap_start;
    logic        ap_done;
    logic [10:0] write_address;
    logic [31:0] write_data;
    logic        write_enable;

    logic        start1;
    logic        done1;
    logic [10:0] addr1;
    logic [31:0] data1;
    logic        wen1;

    int errors = 0;
    int checks = 0;
    int strobes;
    int exp_addr;

    top_main_core #(.N_WORDS(2048)) u_dut (
        .sys_clk       (clk),
        .sys_resetn    (rst_n),
        .clk_en        (clk_en),
        .breakpoint    (breakpoint),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable)
    );

    top_main_core #(.N_WORDS(1)) u_one (
        .sys_clk       (clk),
        .sys_resetn    (rst_n),
        .clk_en        (clk_en),
        .breakpoint    (breakpoint),
        .ap_start      (start1),
        .ap_done       (done1),
        .write_address (addr1),
        .write_data    (data1),
        .write_enable  (wen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tri_num(input int unsigned i);
        logic [63:0] p;
        p = 64'(i) * 64'(i + 1);
        return p[32:1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; every strobe of the main instance is checked against
    // the expected next address and its triangular number.
    task automatic tick();
        @(negedge clk);
        if (write_enable === 1'b1) begin
            check("strobe_addr", 32'(write_address), 32'(exp_addr));
            check("strobe_data", write_data, tri_num(int'(unsigned'(write_address))));
            exp_addr++;
            strobes++;
        end
    endtask

    task automatic run_until_done();
        int n;
        n = 0;
        while (ap_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check("done_seen", 32'(ap_done), 32'd1);
    endtask

    task automatic run_until_addr(input int a);
        int n;
        n = 0;
        while (!(write_enable === 1'b1 && int'(unsigned'(write_address)) == a) && n < 3000) begin
            tick();
            n++;
        end
        check("addr_reached", 32'(write_address), 32'(a));
    endtask

    task automatic new_run();
        strobes  = 0;
        exp_addr = 0;
        ap_start = 1'b1;
    endtask

    task automatic end_handshake();
        ap_start = 1'b0;
        tick();
        check("done_fall", 32'(ap_done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_en     = 1'b1;
        breakpoint = 32'hFFFF_FFFF;
        ap_start   = 1'b0;
        start1     = 1'b0;
        strobes    = 0;
        exp_addr   = 0;

        // Reset state
        #50;
        check("rst_done",  32'(ap_done), 32'd0);
        check("rst_wen",   32'(write_enable), 32'd0);
        check("rst_addr",  32'(write_address), 32'd0);
        check("rst_data",  write_data, 32'd0);
        #50 rst_n = 1'b1;                  // t=100, a falling edge
        repeat (10) tick();                // idle until t=200
        check("idle_wen",  32'(write_enable), 32'd0);

        // Full run
        new_run();
        tick();
        check("start_lat_wen", 32'(write_enable), 32'd0);
        tick();
        check("first_wen",  32'(write_enable), 32'd1);
        check("first_data", write_data, 32'd0);
        run_until_addr(5);
        check("addr5_data", write_data, 32'd15);
        run_until_done();
        check("last_wen",   32'(write_enable), 32'd1);
        check("last_addr",  32'(write_address), 32'd2047);
        check("last_data",  write_data, 32'd2096128);
        check("run1_count", 32'(strobes), 32'd2048);
        // Hold ap_start: no restart, done stays high
        repeat (5) tick();
        check("hold_done",  32'(ap_done), 32'd1);
        check("hold_count", 32'(strobes), 32'd2048);
        end_handshake();

        // Freeze at idx 100
        new_run();
        run_until_addr(99);
        clk_en = 1'b0;
        repeat (4) begin
            tick();
            check("freeze_wen",  32'(write_enable), 32'd0);
            check("freeze_addr", 32'(write_address), 32'd99);
        end
        clk_en = 1'b1;
        tick();
        check("resume_addr", 32'(write_address), 32'd100);
        check("resume_data", write_data, 32'd5050);
        run_until_done();
        check("run2_count", 32'(strobes), 32'd2048);
        end_handshake();

        // Breakpoint at 10 run cycles
        breakpoint = 32'd10;
        new_run();
        repeat (30) tick();
        check("bp_count", 32'(strobes), 32'd10);
        check("bp_addr",  32'(write_address), 32'd9);
        check("bp_wen",   32'(write_enable), 32'd0);
        check("bp_done",  32'(ap_done), 32'd0);
        breakpoint = 32'hFFFF_FFFF;
        tick();
        check("bp_resume_addr", 32'(write_address), 32'd10);
        check("bp_resume_data", write_data, 32'd55);
        run_until_done();
        check("run3_count", 32'(strobes), 32'd2048);
        end_handshake();

        // Breakpoint 0 stalls before the first write
        breakpoint = 32'd0;
        new_run();
        repeat (10) tick();
        check("bp0_count", 32'(strobes), 32'd0);
        breakpoint = 32'hFFFF_FFFF;
        run_until_done();
        check("bp0_run_count", 32'(strobes), 32'd2048);
        end_handshake();

        // Asynchronous reset mid-run at idx 500
        new_run();
        run_until_addr(499);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wen",  32'(write_enable), 32'd0);
        check("arst_addr", 32'(write_address), 32'd0);
        check("arst_data", write_data, 32'd0);
        check("arst_done", 32'(ap_done), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        strobes  = 0;
        exp_addr = 0;
        tick();
        check("rst_restart_lat", 32'(write_enable), 32'd0);
        tick();
        check("rst_restart_addr", 32'(write_address), 32'd0);
        check("rst_restart_wen",  32'(write_enable), 32'd1);
        run_until_done();
        check("run4_count", 32'(strobes), 32'd2048);
        end_handshake();

        // Single-word instance
        start1 = 1'b1;
        tick();
        check("one_lat_wen", 32'(wen1), 32'd0);
        tick();
        check("one_wen",  32'(wen1), 32'd1);
        check("one_addr", 32'(addr1), 32'd0);
        check("one_data", data1, 32'd0);
        check("one_done", 32'(done1), 32'd1);
        tick();
        check("one_wen_off", 32'(wen1), 32'd0);
        check("one_hold",    32'(done1), 32'd1);
        start1 = 1'b0;
        tick();
        check("one_done_fall", 32'(done1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
